// File: rtl/ifu_pkg.sv
// ifu_pkg: shared definitions for the instruction fetch unit.
//   - default PC / instruction widths
//   - PC-source select encodings driven by the controller
//   - End opcode and the full End instruction word
//   - fetch FSM state type
package ifu_pkg;

  localparam int IFU_PC_W    = 6;
  localparam int IFU_INSTR_W = 20;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_JMP  = 2'b10;
  localparam logic [1:0] PC_TRAP = 2'b11;

  localparam logic [3:0]             OPC_END  = 4'b1110;
  localparam logic [IFU_INSTR_W-1:0] END_WORD = {OPC_END, {(IFU_INSTR_W-4){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_HALT = 2'b11
  } ifu_state_e;

endpackage

// File: rtl/ifu_pc_reg.sv
// ifu_pc_reg: program counter register with its next-PC mux.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset (pc -> RESET_PC)
//   load        apply sel this cycle (already gated by the caller)
//   sel         PC source: hold / increment (wraps) / jump to gamma / trap-hold
//   gamma       jump target
//   pc          current program counter
//   next_pc     value pc takes at the next edge (combinational)
module ifu_pc_reg
  import ifu_pkg::*;
#(
  parameter int              PC_W     = IFU_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [1:0]      sel,
  input  logic [PC_W-1:0] gamma,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] next_pc
);

  // Increment relies on natural PC_W-bit wrap (all ones -> zero).
  always_comb begin
    next_pc = pc;
    if (load) begin
      case (sel)
        PC_INC:  next_pc = pc + PC_W'(1);
        PC_JMP:  next_pc = gamma;
        default: next_pc = pc;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= next_pc;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC and the instruction register; fetches one
// instruction word per controller request over an imem req/valid handshake.
// Ports:
//   clk, rst_n            clock / asynchronous active-low reset
//   fetch_req             strobe: fetch at the (next) PC; ignored when busy/halted
//   pc_load, pc_sel       strobe + PC source (hold/inc/jump/trap-hold)
//   gamma                 jump target
//   halt                  level: stop after any outstanding fetch completes
//   imem_rd, imem_addr    memory read request (one cycle) and latched address
//   imem_rdata,imem_valid memory response
//   instruction           instruction register, changes only on capture/reset
//   instr_valid           one-cycle pulse after instruction is updated
//   pc                    current program counter
//   busy                  fetch outstanding
//   fetch_err             sticky fetch timeout flag
// Build option: define IFU_FETCH_TIMEOUT_EN to abort a fetch after TIMEOUT
// wait cycles, loading the End instruction and setting fetch_err. Without it
// the unit waits indefinitely and fetch_err is tied low.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int              PC_W     = IFU_PC_W,
  parameter int              INSTR_W  = IFU_INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_req,
  input  logic               pc_load,
  input  logic [1:0]         pc_sel,
  input  logic [PC_W-1:0]    gamma,
  input  logic               halt,
  output logic               imem_rd,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc,
  output logic               busy,
  output logic               fetch_err
);

  localparam logic [INSTR_W-1:0] END_INSTR = {OPC_END, {(INSTR_W-4){1'b0}}};

  ifu_state_e        state_q, state_d;
  logic [PC_W-1:0]   next_pc;
  logic              pc_en;
  logic              start;
  logic              capture;
  logic              timeout_hit;
  logic              halt_seen_q;
  logic              halt_any;

  // PC is frozen once halted; otherwise every pc_load is honoured, even mid-fetch.
  assign pc_en = pc_load && (state_q != S_HALT);

  ifu_pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (pc_en),
    .sel     (pc_sel),
    .gamma   (gamma),
    .pc      (pc),
    .next_pc (next_pc)
  );

  assign imem_rd  = (state_q == S_REQ);
  assign busy     = (state_q == S_REQ) || (state_q == S_WAIT);
  // A halt seen at any point during the fetch is remembered, so a short
  // halt pulse still stops the unit once the fetch lands.
  assign halt_any = halt || halt_seen_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (halt) begin
          state_d = S_HALT;
        end else if (fetch_req) begin
          state_d = S_REQ;
          start   = 1'b1;
        end
      end
      // REQ accepts a same-cycle response so zero-wait memory skips WAIT.
      S_REQ, S_WAIT: begin
        if (imem_valid) begin
          capture = 1'b1;
          state_d = halt_any ? S_HALT : S_IDLE;
        end else if (timeout_hit) begin
          state_d = halt_any ? S_HALT : S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Fetch address uses next_pc so a same-cycle pc_load is honoured by the fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_addr   <= '0;
      instruction <= '0;
      instr_valid <= 1'b0;
      halt_seen_q <= 1'b0;
    end else begin
      instr_valid <= capture || timeout_hit;
      if (start) imem_addr <= next_pc;
      if (capture)          instruction <= imem_rdata;
      else if (timeout_hit) instruction <= END_INSTR;
      if (busy && halt) halt_seen_q <= 1'b1;
    end
  end

`ifdef IFU_FETCH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] wait_cnt_q;
  logic            fetch_err_q;

  // Counts WAIT cycles without a response; fires on the TIMEOUT-th one.
  assign timeout_hit = (state_q == S_WAIT) && !imem_valid &&
                       (wait_cnt_q == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q  <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      if ((state_q == S_WAIT) && !imem_valid) wait_cnt_q <= wait_cnt_q + TO_W'(1);
      else                                    wait_cnt_q <= '0;
      if (timeout_hit) fetch_err_q <= 1'b1;
    end
  end

  assign fetch_err = fetch_err_q;
`else
  assign timeout_hit = 1'b0;
  assign fetch_err   = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed stimulus pushes expected
// read addresses and expected captured instructions; a monitor pops and
// compares on every imem_rd and instr_valid cycle.
module tb_instr_fetch_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req;
  logic        pc_load;
  logic [1:0]  pc_sel;
  logic [5:0]  gamma;
  logic        halt;
  logic        imem_rd;
  logic [5:0]  imem_addr;
  logic [19:0] imem_rdata;
  logic        imem_valid;
  logic [19:0] instruction;
  logic        instr_valid;
  logic [5:0]  pc;
  logic        busy;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  logic [19:0] mem [64];
  int          lat  = 0;
  bit          mute = 1'b0;
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [5:0]  pend_addr = '0;

  logic [5:0]  exp_addr_q  [$];
  logic [19:0] exp_instr_q [$];

  instr_fetch_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .pc_load     (pc_load),
    .pc_sel      (pc_sel),
    .gamma       (gamma),
    .halt        (halt),
    .imem_rd     (imem_rd),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  // Memory model: lat==0 answers in the imem_rd cycle, else lat cycles later.
  // The pending response deliberately survives a DUT reset.
  always_comb begin
    imem_valid = 1'b0;
    imem_rdata = mem[pend_addr];
    if (lat == 0) begin
      imem_valid = imem_rd && !mute;
      imem_rdata = mem[imem_addr];
    end else begin
      imem_valid = pend && (pend_cnt == 0);
    end
  end

  always @(posedge clk) begin
    if (pend) begin
      if (pend_cnt == 0) pend <= 1'b0;
      else               pend_cnt <= pend_cnt - 1;
    end else if (imem_rd && lat > 0 && !mute) begin
      pend      <= 1'b1;
      pend_cnt  <= lat - 1;
      pend_addr <= imem_addr;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    fetch_req = 1'b0;
    pc_load   = 1'b0;
    pc_sel    = 2'b00;
    gamma     = '0;
  endtask

  task automatic expect_fetch(input logic [5:0] addr, input logic [19:0] data);
    exp_addr_q.push_back(addr);
    exp_instr_q.push_back(data);
  endtask

  task automatic load_pc(input logic [1:0] sel, input logic [5:0] g);
    pc_load = 1'b1; pc_sel = sel; gamma = g;
    tick();
    clear_inputs();
  endtask

  task automatic fetch_pulse();
    fetch_req = 1'b1;
    tick();
    clear_inputs();
  endtask

  task automatic wait_ivalid(input int maxc, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      tick();
      if (instr_valid) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s instr_valid actual=0 required=1 within %0d cycles", name, maxc);
    end
  endtask

  task automatic monitor_step();
    logic [5:0]  ea;
    logic [19:0] ei;
    if (rst_n) begin
      if (imem_rd) begin
        if (exp_addr_q.size() == 0) chk("unexpected_imem_rd", 32'(imem_addr), 32'hFFFF_FFFF);
        else begin
          ea = exp_addr_q.pop_front();
          chk("imem_addr", 32'(imem_addr), 32'(ea));
        end
      end
      if (instr_valid) begin
        if (exp_instr_q.size() == 0) chk("unexpected_instr_valid", 32'(instruction), 32'hFFFF_FFFF);
        else begin
          ei = exp_instr_q.pop_front();
          chk("instruction", 32'(instruction), 32'(ei));
        end
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_pc"},          32'(pc),          32'h0);
    chk({tag, "_instruction"}, 32'(instruction), 32'h0);
    chk({tag, "_instr_valid"}, 32'(instr_valid), 32'h0);
    chk({tag, "_imem_rd"},     32'(imem_rd),     32'h0);
    chk({tag, "_imem_addr"},   32'(imem_addr),   32'h0);
    chk({tag, "_busy"},        32'(busy),        32'h0);
    chk({tag, "_fetch_err"},   32'(fetch_err),   32'h0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 20'h10000 | 20'(i);
    mem[0]  = 20'h4A123;
    mem[7]  = 20'h7B777;
    mem[8]  = 20'h8C888;
    mem[12] = 20'h2C0C0;
    mem[13] = 20'h3D0D0;

    clear_inputs();
    halt  = 1'b0;
    rst_n = 1'b0;

    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
      begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    tick(); tick();
    check_reset_values("reset");
    rst_n = 1'b1;
    tick();

    // Zero-wait fetch: rd at N+1, instr_valid at N+2
    lat = 0;
    expect_fetch(6'd0, 20'h4A123);
    fetch_pulse();
    chk("zw_imem_rd_n1", 32'(imem_rd), 32'h1);
    chk("zw_busy_n1",    32'(busy),    32'h1);
    chk("zw_addr_n1",    32'(imem_addr), 32'h0);
    tick();
    chk("zw_instr_valid_n2", 32'(instr_valid), 32'h1);
    chk("zw_instruction_n2", 32'(instruction), 32'h4A123);
    chk("zw_busy_n2",        32'(busy),        32'h0);
    tick();
    chk("zw_instr_valid_n3", 32'(instr_valid), 32'h0);
    chk("zw_instr_hold",     32'(instruction), 32'h4A123);

    // PC increment wraps 63 -> 0, then a fetch reads address 0
    load_pc(2'b10, 6'd63);
    chk("jmp63_pc", 32'(pc), 32'd63);
    load_pc(2'b01, 6'd0);
    chk("wrap_pc", 32'(pc), 32'd0);
    expect_fetch(6'd0, 20'h4A123);
    fetch_pulse();
    tick(); tick();

    // Hold encodings
    load_pc(2'b10, 6'd5);
    chk("jmp5_pc", 32'(pc), 32'd5);
    load_pc(2'b11, 6'd40);
    chk("trap_hold_pc", 32'(pc), 32'd5);
    load_pc(2'b00, 6'd41);
    chk("hold_pc", 32'(pc), 32'd5);

    // Jump with same-cycle fetch uses the new PC
    expect_fetch(6'd12, 20'h2C0C0);
    pc_load = 1'b1; pc_sel = 2'b10; gamma = 6'd12; fetch_req = 1'b1;
    tick();
    clear_inputs();
    chk("jf_pc",   32'(pc),        32'd12);
    chk("jf_addr", 32'(imem_addr), 32'd12);
    tick(); tick();

    // Increment with same-cycle fetch
    expect_fetch(6'd13, 20'h3D0D0);
    pc_load = 1'b1; pc_sel = 2'b01; fetch_req = 1'b1;
    tick();
    clear_inputs();
    chk("if_pc", 32'(pc), 32'd13);
    tick(); tick();

    // Wait states; pc_load and ignored fetch_req during the wait
    load_pc(2'b10, 6'd7);
    lat = 3;
    expect_fetch(6'd7, 20'h7B777);
    fetch_pulse();
    tick();
    chk("ws_busy_wait", 32'(busy),    32'h1);
    chk("ws_rd_low",    32'(imem_rd), 32'h0);
    pc_load = 1'b1; pc_sel = 2'b01; fetch_req = 1'b1;
    tick();
    clear_inputs();
    chk("ws_pc_mid", 32'(pc), 32'd8);
    chk("ws_addr_kept", 32'(imem_addr), 32'd7);
    wait_ivalid(8, "ws_capture");
    chk("ws_pc_after", 32'(pc), 32'd8);
    tick(); tick(); tick();

    // Halt during WAIT: fetch completes, then frozen
    expect_fetch(6'd8, 20'h8C888);
    fetch_pulse();
    tick();
    halt = 1'b1;
    wait_ivalid(8, "halt_capture");
    for (int i = 0; i < 20; i++) begin
      fetch_req = 1'b1; pc_load = 1'b1; pc_sel = 2'b01;
      tick();
      clear_inputs();
      tick();
    end
    chk("halt_pc_frozen", 32'(pc),          32'd8);
    chk("halt_busy",      32'(busy),        32'h0);
    chk("halt_instr",     32'(instruction), 32'h8C888);
    halt = 1'b0;
    fetch_pulse();
    tick(); tick();
    chk("halt_sticky_rd", 32'(imem_rd), 32'h0);

    // Reset exits HALT
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_values("rst_halt");

    // Reset mid-WAIT; the late response must be ignored
    expect_fetch(6'd20, 20'h10014);
    void'(exp_instr_q.pop_back());
    pc_load = 1'b1; pc_sel = 2'b10; gamma = 6'd20; fetch_req = 1'b1;
    tick();
    clear_inputs();
    chk("rm_pc", 32'(pc), 32'd20);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("rst_mid");
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick(); tick();
    chk("rm_late_ignored", 32'(instruction), 32'h0);
    chk("rm_idle_busy",    32'(busy),        32'h0);

    // Recovery fetch with one wait cycle
    lat = 1;
    expect_fetch(6'd0, 20'h4A123);
    fetch_pulse();
    wait_ivalid(6, "recover_capture");
    tick();

`ifdef IFU_FETCH_TIMEOUT_EN
    mute = 1'b1;
    expect_fetch(6'd0, 20'hE0000);
    fetch_pulse();
    wait_ivalid(TIMEOUT + 6, "timeout_end_word");
    tick();
    chk("to_fetch_err",        32'(fetch_err), 32'h1);
    tick(); tick(); tick();
    chk("to_fetch_err_sticky", 32'(fetch_err), 32'h1);
    chk("to_idle",             32'(busy),      32'h0);
    mute = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("to_err_cleared", 32'(fetch_err), 32'h0);
`else
    chk("no_timeout_fetch_err", 32'(fetch_err), 32'h0);
`endif

    tick(); tick();
    chk("addr_queue_drained",  32'(exp_addr_q.size()),  32'h0);
    chk("instr_queue_drained", 32'(exp_instr_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Upstream neighbour of the processor control FSM. It owns the program counter and the instruction register. It fetches 20-bit instruction words from instruction memory over a req/valid handshake and presents a stable `instruction[19:0]` to the controller. The PC is updated from the controller's PC-source select (M3 encoding) and 6-bit jump target (gamma).

Parameters:
- PC_W, 6, program counter / instruction memory address width.
- INSTR_W, 20, instruction word width; opcode is the top 4 bits.
- RESET_PC, 0, PC value after reset.
- TIMEOUT, 16, max wait cycles for imem_valid (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_req  in  1  single-cycle strobe from controller: start a fetch at the current PC.
- pc_load  in  1  single-cycle strobe: apply pc_sel this cycle.
- pc_sel  in  2  PC source: 00 hold, 01 PC+1, 10 load gamma, 11 hold (trap).
- gamma  in  PC_W  jump target.
- halt  in  1  controller End; level-sensitive.
- imem_rd  out  1  memory read request.
- imem_addr  out  PC_W  memory read address.
- imem_rdata  in  INSTR_W  memory read data, valid with imem_valid.
- imem_valid  in  1  read data valid, single cycle.
- instruction  out  INSTR_W  instruction register to controller.
- instr_valid  out  1  one-cycle pulse when instruction is newly updated.
- pc  out  PC_W  current program counter.
- busy  out  1  fetch outstanding.
- fetch_err  out  1  sticky timeout flag (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (async, rst_n=0) sets: pc=RESET_PC, instruction=0, instr_valid=0, imem_rd=0, imem_addr=0, busy=0, fetch_err=0, FSM=IDLE.
- FSM states: IDLE, REQ, WAIT, HALT.
- IDLE:
  - halt=1 → HALT.
  - Otherwise fetch_req=1 → REQ, latch imem_addr=pc, busy=1.
- REQ:
  - imem_rd=1 for exactly one cycle → WAIT.
  - If imem_valid is already 1 in this cycle, capture and go straight to IDLE (zero-wait memory).
- WAIT:
  - imem_rd=0; hold until imem_valid.
  - On imem_valid: instruction<=imem_rdata; instr_valid=1 the next cycle for one cycle; busy=0; → IDLE.
- Minimum latency: fetch_req at cycle N, imem_rd at N+1, instr_valid at N+2 with a zero-wait memory.
- instruction holds its value between fetches; it never changes except on a capture or reset.
- PC update happens on pc_load=1, in any state except HALT:
  - pc_sel 01: pc<=pc+1, wrapping mod 2^PC_W (63→0).
  - pc_sel 10: pc<=gamma.
  - pc_sel 00 or 11: pc unchanged.
- Simultaneous pc_load and fetch_req in IDLE: the fetch uses the updated PC (next-PC value); imem_addr = next_pc.
- pc_load while busy: PC updates, but the outstanding fetch keeps its latched imem_addr.
- fetch_req while busy or in HALT: ignored, no error.
- halt=1:
  - From IDLE → HALT immediately.
  - In REQ/WAIT, the outstanding fetch completes (instruction captured), then → HALT.
- HALT is exited only by reset. pc is frozen and no imem_rd is issued.
- Reset mid-fetch: all state clears asynchronously. A late imem_valid after reset is ignored (FSM in IDLE).

Optional Feature:
- Macro IFU_FETCH_TIMEOUT_EN.
- Defined:
  - A wait counter runs in WAIT.
  - If imem_valid is not seen within TIMEOUT cycles after imem_rd, instruction<=20'hE0000 (End opcode 1110) and instr_valid pulses, so the controller stops cleanly.
  - fetch_err<=1 (sticky until reset); FSM → IDLE.
- Undefined: no counter; WAIT waits indefinitely; fetch_err tied 0.

Decomposition:
- Shared package ifu_pkg:
  - PC_W and INSTR_W defaults.
  - pc_sel encodings PC_HOLD=2'b00, PC_INC=2'b01, PC_JMP=2'b10, PC_TRAP=2'b11.
  - OPC_END=4'b1110 and the END_WORD constant.
  - FSM state typedef.
- One natural sub-module, ifu_pc_reg: PC register plus next-PC mux (hold/inc/jump, wrap), exposing next_pc combinationally.

Test Plan:
- Zero-wait fetch: reset, pc=0, mem[0]=20'h4A123, fetch_req → imem_rd at +1 with addr 0, instruction=20'h4A123 and instr_valid pulse at +2.
- Increment wrap: jump pc_sel=10 gamma=63, then pc_load pc_sel=01 → pc=0; a fetch then reads addr 0.
- Jump plus same-cycle fetch: pc=5, pc_load pc_sel=10 gamma=12 with fetch_req → imem_addr=12, pc=12.
- Wait states and pc_load during a fetch: 3-cycle memory latency at addr 7, pc_load INC mid-wait → capture comes from addr 7, pc=8. A fetch_req during the wait is ignored: exactly one imem_rd.
- Halt: halt asserted in WAIT → instruction captured, then no further imem_rd after 20 fetch_req pulses, and pc frozen. Reset mid-WAIT → all outputs return to reset values.
- With IFU_FETCH_TIMEOUT_EN: no imem_valid for TIMEOUT=16 cycles → instruction=20'hE0000, instr_valid pulse, fetch_err=1 and held until reset.
